// File: rtl/seq_calc_pkg.sv
// Shared types and constants for the sequential add/sub/mul/div unit.
package seq_calc_pkg;

   localparam int DEFAULT_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Step counter width; at least one bit even for the narrowest unit.
   function automatic int cnt_width(input int data_w);
      return (data_w <= 2) ? 1 : $clog2(data_w);
   endfunction

endpackage

// File: rtl/seq_calc_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial
// subtract the divisor, keep the difference only when it did not go negative.
module seq_calc_div_step
   import seq_calc_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic [DATA_W-1:0] rem,
   input  logic              next_bit,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] new_rem,
   output logic              q_bit
);

   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;

   always_comb begin
      shifted = {rem, next_bit};
      diff    = shifted - {1'b0, divisor};
      // The extra top bit acts as the borrow: set means the trial went negative.
      q_bit   = ~diff[DATA_W];
      new_rem = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
   end

endmodule

// File: rtl/seq_calc_unit.sv
// Multi-cycle add/sub/shift-add mul/restoring div unit behind a start/done handshake.
// Optional remainder output port enabled by SEQ_CALC_REMAINDER_EN.
module seq_calc_unit
   import seq_calc_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_run,
   input  logic [DATA_W-1:0] i_value_a,
   input  logic [DATA_W-1:0] i_value_b,
   output logic              o_idle,
   output logic              o_running,
   output logic              o_done,
   output logic [DATA_W-1:0] o_value_add,
   output logic [DATA_W-1:0] o_value_sub,
   output logic [DATA_W-1:0] o_value_mul,
   output logic [DATA_W-1:0] o_value_div,
`ifdef SEQ_CALC_REMAINDER_EN
   output logic [DATA_W-1:0] o_value_rem,
`endif
   output logic              o_div_by_zero
);

   localparam int              CW   = cnt_width(DATA_W);
   localparam logic [CW-1:0]   LAST = CW'(DATA_W - 1);

   state_t state_reg, state_next;

   logic [CW-1:0]     cnt_reg;
   logic [DATA_W-1:0] mcand_reg;
   logic [DATA_W-1:0] mplier_reg;
   logic [DATA_W-1:0] divisor_reg;
   logic [DATA_W-1:0] prod_reg;
   logic [DATA_W-1:0] rem_reg;
   logic [DATA_W-1:0] quo_reg;
   logic [DATA_W-1:0] add_reg;
   logic [DATA_W-1:0] sub_reg;
   logic              dz_reg;

   logic [DATA_W-1:0] out_add_reg;
   logic [DATA_W-1:0] out_sub_reg;
   logic [DATA_W-1:0] out_mul_reg;
   logic [DATA_W-1:0] out_div_reg;
   logic [DATA_W-1:0] out_rem_reg;
   logic              out_dz_reg;
   logic              done_reg;

   logic [DATA_W-1:0] step_rem;
   logic              step_q;

   seq_calc_div_step #(
      .DATA_W (DATA_W)
   ) u_div_step (
      .rem      (rem_reg),
      .next_bit (quo_reg[DATA_W-1]),
      .divisor  (divisor_reg),
      .new_rem  (step_rem),
      .q_bit    (step_q)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (i_run) state_next = RUN;
         RUN:     if (cnt_reg == LAST) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg     <= '0;
         mcand_reg   <= '0;
         mplier_reg  <= '0;
         divisor_reg <= '0;
         prod_reg    <= '0;
         rem_reg     <= '0;
         quo_reg     <= '0;
         add_reg     <= '0;
         sub_reg     <= '0;
         dz_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (i_run) begin
                  add_reg     <= i_value_a + i_value_b;
                  sub_reg     <= i_value_a - i_value_b;
                  mcand_reg   <= i_value_a;
                  mplier_reg  <= i_value_b;
                  divisor_reg <= i_value_b;
                  prod_reg    <= '0;
                  rem_reg     <= '0;
                  quo_reg     <= i_value_a;
                  cnt_reg     <= '0;
                  dz_reg      <= (i_value_b == '0);
               end
            end
            RUN: begin
               // Multiplier consumed LSB first against a left-shifting multiplicand.
               if (mplier_reg[0]) begin
                  prod_reg <= prod_reg + mcand_reg;
               end
               mcand_reg  <= mcand_reg << 1;
               mplier_reg <= mplier_reg >> 1;
               rem_reg    <= step_rem;
               quo_reg    <= {quo_reg[DATA_W-2:0], step_q};
               cnt_reg    <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Results are published from DONE so the outputs stay stable while the next
   // request is being worked on.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_add_reg <= '0;
         out_sub_reg <= '0;
         out_mul_reg <= '0;
         out_div_reg <= '0;
         out_rem_reg <= '0;
         out_dz_reg  <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= (state_reg == DONE);
         if (state_reg == DONE) begin
            out_add_reg <= add_reg;
            out_sub_reg <= sub_reg;
            out_mul_reg <= prod_reg;
            out_div_reg <= quo_reg;
            out_rem_reg <= rem_reg;
            out_dz_reg  <= dz_reg;
         end
      end
   end

   assign o_idle        = (state_reg == IDLE);
   assign o_running     = (state_reg == RUN);
   assign o_done        = done_reg;
   assign o_value_add   = out_add_reg;
   assign o_value_sub   = out_sub_reg;
   assign o_value_mul   = out_mul_reg;
   assign o_value_div   = out_div_reg;
   assign o_div_by_zero = out_dz_reg;
`ifdef SEQ_CALC_REMAINDER_EN
   assign o_value_rem   = out_rem_reg;
`else
   logic unused_rem;
   assign unused_rem = ^out_rem_reg;
`endif

endmodule
